stream_integrate_dump: RTL and testbench

Integrate-and-dump decimator placed directly downstream of the stream multiplier in the lock-in signal path. It sums a runtime-programmable number N of valid signed product samples and emits one full-precision sum per frame, then restarts. Streams carry tvalid only, with no backpressure, matching the rest of the datapath.

---
 rtl/stream_integrate_dump_pkg.sv | 18 +
 rtl/stream_integrate_dump_if.sv | 10 +
 rtl/stream_integrate_dump.sv | 123 ++++++++++++
 tb/tb_stream_integrate_dump.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/stream_integrate_dump_pkg.sv
// Shared stream-path constants: FSM encodings and the frame-sum width rule
// used by the integrator and everything that consumes its output.
package stream_integrate_dump_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_LEN_WIDTH  = 16;

    // A sum of up to 2^lw-1 samples of dw signed bits never needs more than dw+lw bits.
    function automatic int out_width(input int dw, input int lw);
        return dw + lw;
    endfunction

endpackage

// File: rtl/stream_integrate_dump_if.sv
// Valid-only stream (no backpressure) used between datapath stages.
interface stream_integrate_dump_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;

    modport master (output tdata, output tvalid);
    modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/stream_integrate_dump.sv
// Integrate-and-dump decimator: sums N valid signed samples at full precision
// and emits one sum per frame, restarting immediately when still enabled.
module stream_integrate_dump
    import stream_integrate_dump_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    stream_integrate_dump_if.slave  data_i,
    stream_integrate_dump_if.master data_o,
    output logic                    busy_o,
    output logic [LEN_WIDTH-1:0]    count_o
);

    localparam int OUT_WIDTH = out_width(DATA_WIDTH, LEN_WIDTH);

    state_t                 state_reg;
    state_t                 state_next;
    logic [OUT_WIDTH-1:0]   acc_reg;
    logic [LEN_WIDTH-1:0]   cnt_reg;
    logic [LEN_WIDTH-1:0]   len_reg;
    logic [OUT_WIDTH-1:0]   out_data_reg;
    logic                   out_valid_reg;

    logic [OUT_WIDTH-1:0]   sample_ext;
    logic [OUT_WIDTH-1:0]   sum_next;
    logic                   start_ok;
    logic                   last_sample;
    logic                   accum_take;
    logic                   dump;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_sext
            if (gi < DATA_WIDTH) begin : g_lo
                assign sample_ext[gi] = data_i.tdata[gi];
            end else begin : g_hi
                assign sample_ext[gi] = data_i.tdata[DATA_WIDTH-1];
            end
        end
    endgenerate

    // Two's-complement add on the sign-extended operand is exact at this width.
    assign sum_next    = acc_reg + sample_ext;
    assign start_ok    = enable_i && (len_i != '0);
    assign last_sample = (cnt_reg == (len_reg - LEN_WIDTH'(1)));
    assign accum_take  = (state_reg == ST_ACCUM) && enable_i && data_i.tvalid;
    assign dump        = accum_take && last_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Abort wins over a coincident dump.
                if (!enable_i) begin
                    state_next = ST_IDLE;
                end else if (dump && !start_ok) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg       <= '0;
            cnt_reg       <= '0;
            len_reg       <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                acc_reg <= '0;
                cnt_reg <= '0;
                if (start_ok) begin
                    len_reg <= len_i;
                end
            end else if (!enable_i) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else if (dump) begin
                out_data_reg  <= sum_next;
                out_valid_reg <= 1'b1;
                acc_reg       <= '0;
                cnt_reg       <= '0;
                if (start_ok) begin
                    len_reg <= len_i;
                end
            end else if (accum_take) begin
                acc_reg <= sum_next;
                cnt_reg <= cnt_reg + LEN_WIDTH'(1);
            end
        end
    end

    always_comb begin
        busy_o  = (state_reg == ST_ACCUM);
        count_o = cnt_reg;
    end

    assign data_o.tdata  = out_data_reg;
    assign data_o.tvalid = out_valid_reg;

endmodule

// File: tb/tb_stream_integrate_dump.sv
// Directed bench for stream_integrate_dump; a second instance runs in parallel
// so both full-scale frame-length extremes share one 65535-sample pass.
module tb_stream_integrate_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] len;
    logic        busy_a, busy_b;
    logic [15:0] count_a, count_b;
    int          checks   = 0;
    int          failures = 0;
    logic        seen_pulse;

    stream_integrate_dump_if #(.WIDTH(16)) in_a ();
    stream_integrate_dump_if #(.WIDTH(16)) in_b ();
    stream_integrate_dump_if #(.WIDTH(32)) out_a ();
    stream_integrate_dump_if #(.WIDTH(32)) out_b ();

    stream_integrate_dump #(.DATA_WIDTH(16), .LEN_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .enable_i(enable), .len_i(len),
        .data_i(in_a), .data_o(out_a), .busy_o(busy_a), .count_o(count_a)
    );

    stream_integrate_dump #(.DATA_WIDTH(16), .LEN_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .enable_i(enable), .len_i(len),
        .data_i(in_b), .data_o(out_b), .busy_o(busy_b), .count_o(count_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input longint d, input logic b, input int c);
        chk({tag, ".tvalid"}, out_a.tvalid, v);
        chk({tag, ".tdata"},  $signed(out_a.tdata), d);
        chk({tag, ".busy"},   busy_a, b);
        chk({tag, ".count"},  count_a, c);
        $display("step %-10s tvalid=%0b tdata=%0d busy=%0b count=%0d", tag, out_a.tvalid,
                 $signed(out_a.tdata), busy_a, count_a);
    endtask

    task automatic step(input logic v, input logic signed [15:0] d);
        in_a.tvalid = v;
        in_a.tdata  = d;
        in_b.tvalid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; len = 16'd0;
        in_a.tvalid = 1'b0; in_a.tdata = '0;
        in_b.tvalid = 1'b0; in_b.tdata = 16'sd32767;
        step(0, 0); step(0, 0);
        chk_out("reset", 0, 0, 0, 0);

        // N=4, back-to-back; the valid sample in the start cycle is ignored
        reset = 1'b0; enable = 1'b1; len = 16'd4;
        step(1, 99);  chk_out("t1_start", 0, 0, 1, 0);
        step(1, 1);   chk_out("t1_s1", 0, 0, 1, 1);
        step(1, 2);   chk_out("t1_s2", 0, 0, 1, 2);
        step(1, 3);   chk_out("t1_s3", 0, 0, 1, 3);
        step(1, 4);   chk_out("t1_dump", 1, 10, 1, 0);
        enable = 1'b0;
        step(0, 0);   chk_out("t1_idle", 0, 10, 0, 0);

        // N=3 with invalid gaps
        enable = 1'b1; len = 16'd3;
        step(0, 0);   chk_out("t2_start", 0, 10, 1, 0);
        step(1, 5);   chk_out("t2_s1", 0, 10, 1, 1);
        step(0, 55);  chk_out("t2_gap1", 0, 10, 1, 1);
        step(0, 66);  chk_out("t2_gap2", 0, 10, 1, 1);
        step(1, -7);  chk_out("t2_s2", 0, 10, 1, 2);
        step(0, 77);  step(0, 88);
        chk_out("t2_gap3", 0, 10, 1, 2);
        step(1, 100); chk_out("t2_dump", 1, 98, 1, 0);
        enable = 1'b0;
        step(0, 0);   chk_out("t2_idle", 0, 98, 0, 0);

        // N=1 continuous
        enable = 1'b1; len = 16'd1;
        step(0, 0);   chk_out("t3_start", 0, 98, 1, 0);
        step(1, -3);  chk_out("t3_o1", 1, -3, 1, 0);
        step(1, 4);   chk_out("t3_o2", 1, 4, 1, 0);
        step(1, 0);   chk_out("t3_o3", 1, 0, 1, 0);
        enable = 1'b0;
        step(0, 0);   chk_out("t3_idle", 0, 0, 0, 0);

        // N=65535 at both full-scale extremes (dut_b sees +32767 throughout)
        enable = 1'b1; len = 16'hFFFF;
        step(0, 0);
        seen_pulse = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            step(1, -16'sd32768);
            if (out_a.tvalid || out_b.tvalid) seen_pulse = 1'b1;
        end
        chk("t4_no_early_pulse", seen_pulse, 0);
        chk("t4_count", count_a, 65534);
        step(1, -16'sd32768);
        chk("t4_neg_valid", out_a.tvalid, 1);
        chk("t4_neg_sum", $signed(out_a.tdata), -64'sd2147450880);
        chk("t4_pos_valid", out_b.tvalid, 1);
        chk("t4_pos_sum", $signed(out_b.tdata), 64'sd2147385345);
        $display("step t4_dump    neg=%0d pos=%0d", $signed(out_a.tdata), $signed(out_b.tdata));
        enable = 1'b0;
        step(0, 0);   chk_out("t4_idle", 0, -2147450880, 0, 0);

        // len_i change mid-frame takes effect only at the next frame
        enable = 1'b1; len = 16'd4;
        step(0, 0);
        step(1, 10);  step(1, 20);
        len = 16'd2;
        step(1, 30);  chk_out("t5_s3", 0, -2147450880, 1, 3);
        step(1, 40);  chk_out("t5_dump4", 1, 100, 1, 0);
        step(1, 1);   chk_out("t5_f2s1", 0, 100, 1, 1);
        step(1, 2);   chk_out("t5_dump2", 1, 3, 1, 0);
        step(1, 5);
        len = 16'd4;
        step(1, 6);   chk_out("t5_dump2b", 1, 11, 1, 0);
        step(1, 7);   step(1, 8);   step(1, 9);
        chk_out("t5_s3b", 0, 11, 1, 3);
        // abort coinciding with what would be the dumping sample
        enable = 1'b0;
        step(1, 10);  chk_out("t5_abort", 0, 11, 0, 0);

        // reset mid-frame drops a coincident dump and leaves no residue
        enable = 1'b1; len = 16'd3;
        step(0, 0);
        step(1, 50);  step(1, 60);
        chk_out("t6_pre", 0, 11, 1, 2);
        reset = 1'b1;
        step(1, 70);  chk_out("t6_reset", 0, 0, 0, 0);
        reset = 1'b0; len = 16'd2;
        step(0, 0);   chk_out("t6_start", 0, 0, 1, 0);
        step(1, 7);   chk_out("t6_s1", 0, 0, 1, 1);
        step(1, 8);   chk_out("t6_dump", 1, 15, 1, 0);
        step(0, 0);   chk_out("t6_after", 0, 15, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
